// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter from NUM_CORES caches to one memory port.
// Ports:
//   clk, reset_n (sync, active-low)
//   core_req_*    : per-core valid/rw/addr/data in, one-hot ready out
//   core_resp_*   : one-hot completion pulse, shared read data
//   mem_req_*     : single request to memory (valid/ready handshake)
//   mem_resp_*    : one-cycle read response pulse from memory
//   err_timeout   : read watchdog pulse
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the read watchdog;
// otherwise err_timeout is tied low and reads wait indefinitely.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module mem_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int LINE_ADDR_W    = `ADDR_BITS - `OFFSET_BITS,
   parameter int LINE_W         = `CACHELINE_BITS,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_CORES-1:0]             core_req_valid,
   input  logic [NUM_CORES-1:0]             core_req_rw,
   input  logic [NUM_CORES*LINE_ADDR_W-1:0] core_req_addr,
   input  logic [NUM_CORES*LINE_W-1:0]      core_req_data,
   output logic [NUM_CORES-1:0]             core_req_ready,
   output logic [NUM_CORES-1:0]             core_resp_valid,
   output logic [LINE_W-1:0]                core_resp_data,
   output logic                             mem_req_valid,
   output logic                             mem_req_rw,
   output logic [LINE_ADDR_W-1:0]           mem_req_addr,
   output logic [LINE_W-1:0]                mem_req_data,
   input  logic                             mem_req_ready,
   input  logic                             mem_resp_valid,
   input  logic [LINE_W-1:0]                mem_resp_data,
   output logic                             err_timeout
);

   localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   if (NUM_CORES < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("mem_arbiter: NUM_CORES must be >= 2, TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP
   } state_t;

   state_t                   state_q, state_d;
   logic [IDW-1:0]           rr_q, rr_d;
   logic [IDW-1:0]           id_q, id_d;
   logic                     rw_q, rw_d;
   logic [LINE_ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]        data_q, data_d;
   logic [NUM_CORES-1:0]     rsp_v_q, rsp_v_d;
   logic [LINE_W-1:0]        rsp_data_q, rsp_data_d;
   logic [NUM_CORES-1:0]     req_ready;
   logic                     win_found;
   logic [IDW-1:0]           win_id;
   logic [IDW-1:0]           cand;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     tmo_q, tmo_d;
`endif

   // Scan from rr_q upward with wrap; first requester wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = rr_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!win_found && core_req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
         cand = (cand == IDW'(NUM_CORES - 1)) ? '0 : cand + IDW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      id_d       = id_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rsp_v_d    = '0;
      rsp_data_d = '0;
      req_ready  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      tmo_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               req_ready[win_id] = 1'b1;
               id_d    = win_id;
               rw_d    = core_req_rw[win_id];
               addr_d  = core_req_addr[win_id*LINE_ADDR_W +: LINE_ADDR_W];
               data_d  = core_req_data[win_id*LINE_W +: LINE_W];
               rr_d    = (win_id == IDW'(NUM_CORES - 1)) ?
                         '0 : win_id + IDW'(1);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_req_ready) begin
               if (rw_q) begin
                  // Writes complete on handshake; data bus stays zero.
                  rsp_v_d[id_q] = 1'b1;
                  state_d       = IDLE;
               end else begin
                  state_d = WAIT_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         WAIT_RESP: begin
            if (mem_resp_valid) begin
               rsp_v_d[id_q] = 1'b1;
               rsp_data_d    = mem_resp_data;
               state_d       = IDLE;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               // Release the core with zero data so it cannot hang.
               rsp_v_d[id_q] = 1'b1;
               tmo_d         = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         id_q       <= '0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rsp_v_q    <= '0;
         rsp_data_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         id_q       <= id_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rsp_v_q    <= rsp_v_d;
         rsp_data_q <= rsp_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   // Grant is combinational; mask it while reset is held.
   assign core_req_ready  = reset_n ? req_ready : '0;
   assign core_resp_valid = rsp_v_q;
   assign core_resp_data  = rsp_data_q;
   assign mem_req_valid   = (state_q == ISSUE);
   assign mem_req_rw      = rw_q;
   assign mem_req_addr    = addr_q;
   assign mem_req_data    = data_q;

`ifdef MEM_ARB_TIMEOUT_EN
   assign err_timeout = tmo_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Behavioural memory with write-busy and read latency.
module tb_mem_arbiter;
   localparam int NC      = 4;
   localparam int AW      = 8;
   localparam int LW      = 32;
   localparam int WR_BUSY = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [NC-1:0]    core_req_valid = '0;
   logic [NC-1:0]    core_req_rw = '0;
   logic [NC*AW-1:0] core_req_addr = '0;
   logic [NC*LW-1:0] core_req_data = '0;
   logic [NC-1:0]    core_req_ready;
   logic [NC-1:0]    core_resp_valid;
   logic [LW-1:0]    core_resp_data;
   logic             mem_req_valid;
   logic             mem_req_rw;
   logic [AW-1:0]    mem_req_addr;
   logic [LW-1:0]    mem_req_data;
   logic             mem_req_ready;
   logic             mem_resp_valid = 1'b0;
   logic [LW-1:0]    mem_resp_data = '0;
   logic             err_timeout;

   mem_arbiter #(
      .NUM_CORES(NC), .LINE_ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
      .core_req_addr(core_req_addr), .core_req_data(core_req_data),
      .core_req_ready(core_req_ready), .core_resp_valid(core_resp_valid),
      .core_resp_data(core_resp_data), .mem_req_valid(mem_req_valid),
      .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rw;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } mreq_t;

   typedef struct {
      int            id;
      logic [LW-1:0] data;
      bit            rd;
   } resp_t;

   int    exp_grant[$];
   mreq_t exp_mem[$];
   resp_t exp_resp[$];
   int    n_cmp = 0;
   int    n_err = 0;

   function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
      if (a == 8'h12) return 32'hA5A5_A5A5;
      return {a, ~a, a ^ 8'h3C, 8'h5A};
   endfunction

   // Memory model
   logic [LW-1:0] mem_data [256];
   bit            mem_wr [256];
   int            busy_cnt = 0;
   int            rd_cnt = 0;
   int            rd_lat = 3;
   logic [AW-1:0] rd_addr = '0;

   assign mem_req_ready = (busy_cnt == 0);

   always @(posedge clk) begin
      mem_resp_valid <= 1'b0;
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (rd_cnt > 0) begin
         rd_cnt <= rd_cnt - 1;
         if (rd_cnt == 1) begin
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= mem_wr[rd_addr] ? mem_data[rd_addr] : pat(rd_addr);
         end
      end
      if (mem_req_valid && mem_req_ready) begin
         if (mem_req_rw) begin
            mem_data[mem_req_addr] <= mem_req_data;
            mem_wr[mem_req_addr]   <= 1'b1;
            busy_cnt               <= WR_BUSY;
         end else begin
            rd_cnt  <= rd_lat;
            rd_addr <= mem_req_addr;
         end
      end
   end

   // Reference contents as seen by the issuing order
   logic [LW-1:0] ref_mem [256];
   bit            ref_wr [256];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor
   int    mg;
   mreq_t mm;
   resp_t mr;
   logic  mem_resp_prev = 1'b0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (core_req_ready != '0) begin
            check("ready_onehot", 64'($onehot(core_req_ready)), 1);
            if (exp_grant.size() == 0) begin
               check("grant_unexp", 64'(core_req_ready), 0);
            end else begin
               mg = exp_grant.pop_front();
               check("grant", 64'(core_req_ready), 64'(1) << mg);
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            if (exp_mem.size() == 0) begin
               check("memreq_unexp", 1, 0);
            end else begin
               mm = exp_mem.pop_front();
               check("mem_rw", 64'(mem_req_rw), 64'(mm.rw));
               check("mem_addr", 64'(mem_req_addr), 64'(mm.addr));
               if (mm.rw) check("mem_wdata", 64'(mem_req_data), 64'(mm.data));
            end
         end
         if (core_resp_valid != '0) begin
            if (exp_resp.size() == 0) begin
               check("resp_unexp", 64'(core_resp_valid), 0);
            end else begin
               mr = exp_resp.pop_front();
               check("resp_id", 64'(core_resp_valid), 64'(1) << mr.id);
               check("resp_data", 64'(core_resp_data), 64'(mr.data));
               if (mr.rd) check("resp_lat", 64'(mem_resp_prev), 1);
            end
         end
      end
      mem_resp_prev <= mem_resp_valid;
   end

   task automatic expect_txn(input int c, input bit rw,
                             input logic [AW-1:0] a,
                             input logic [LW-1:0] d, input bit resp);
      mreq_t m;
      resp_t r;
      exp_grant.push_back(c);
      m.rw = rw; m.addr = a; m.data = d;
      exp_mem.push_back(m);
      r.id = c; r.rd = !rw;
      r.data = rw ? '0 : (ref_wr[a] ? ref_mem[a] : pat(a));
      if (rw) begin
         ref_mem[a] = d;
         ref_wr[a]  = 1'b1;
      end
      if (resp) exp_resp.push_back(r);
      core_req_rw[c]             = rw;
      core_req_addr[c*AW +: AW]  = a;
      core_req_data[c*LW +: LW]  = d;
   endtask

   task automatic run(input logic [NC-1:0] mask, input int n, input bit hold);
      int got = 0;
      int cyc = 0;
      logic [NC-1:0] g;
      core_req_valid = core_req_valid | mask;
      while (got < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         g = core_req_ready & mask;
         if (g != '0) begin
            got++;
            @(posedge clk);
            #1;
            if (!hold) core_req_valid = core_req_valid & ~g;
         end
      end
      core_req_valid = core_req_valid & ~mask;
      check("grants", 64'(got), 64'(n));
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (exp_resp.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("drain", 64'(exp_resp.size()), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, 64'({core_req_ready, core_resp_valid,
            mem_req_valid, mem_req_rw, err_timeout}), 0);
      check({tag, "_addr"}, 64'(mem_req_addr), 0);
      check({tag, "_data"}, {core_resp_data, mem_req_data}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("rst");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Core 1 read, then mem_req_valid one cycle after accept
      expect_txn(1, 1'b0, 8'h12, 32'h1111_0000, 1'b1);
      run(4'b0010, 1, 1'b0);
      @(negedge clk);
      check("req_lat", 64'(mem_req_valid), 1);
      wait_done();

      // rr_ptr=2: cores 0 and 3 -> 3 first
      expect_txn(3, 1'b0, 8'h40, '0, 1'b1);
      expect_txn(0, 1'b0, 8'h41, '0, 1'b1);
      run(4'b1001, 2, 1'b0);
      wait_done();

      // Write then read-back while memory is busy
      expect_txn(2, 1'b1, 8'h34, 32'hDEAD_BEEF, 1'b1);
      expect_txn(0, 1'b0, 8'h34, '0, 1'b1);
      run(4'b0101, 2, 1'b0);
      @(negedge clk);
      check("held_valid", 64'({mem_req_valid, mem_req_ready}), 64'(2'b10));
      wait_done();

      // Reset while waiting for a slow read
      rd_lat = 10;
      expect_txn(1, 1'b0, 8'h60, '0, 1'b0);
      run(4'b0010, 1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_zero("midrst");
      end
      reset_n = 1'b1;
      cyc = 0;
      while (!mem_resp_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      check("late_resp_seen", 64'(mem_resp_valid), 1);
      @(negedge clk);
      check("late_resp_drop", 64'(core_resp_valid), 0);
      rd_lat = 3;
      @(posedge clk);
      #1;

      // All cores hold valid: order 0,1,2,3,0
      expect_txn(0, 1'b0, 8'h50, '0, 1'b1);
      expect_txn(1, 1'b0, 8'h51, '0, 1'b1);
      expect_txn(2, 1'b1, 8'h52, 32'hCAFE_0052, 1'b1);
      expect_txn(3, 1'b0, 8'h53, '0, 1'b1);
      expect_txn(0, 1'b0, 8'h50, '0, 1'b1);
      run(4'b1111, 5, 1'b1);
      wait_done();

      check("err_timeout", 64'(err_timeout), 0);
      check("q_empty", 64'(exp_grant.size() + exp_mem.size()
            + exp_resp.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter between NUM_CORES private caches and the single shared main memory port. Accepts line-granular read/write requests from each cache, issues one request at a time on the mem_req_*/mem_resp_* interface, and routes each read response back to the requesting cache. Sits directly upstream of main memory; holds at most one transaction in flight.

Parameters:
NUM_CORES, 4, number of requesting caches (≥2)
LINE_ADDR_W, `ADDR_BITS-`OFFSET_BITS, line address width
LINE_W, `CACHELINE_BITS, cache line width
TIMEOUT_CYCLES, 64, read-response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on posedge
reset_n  in  1  synchronous, active-low reset
core_req_valid  in  NUM_CORES  per-core request valid
core_req_rw  in  NUM_CORES  per-core 0=read 1=write
core_req_addr  in  NUM_CORES*LINE_ADDR_W  per-core line address, core i at [i*LINE_ADDR_W +: LINE_ADDR_W]
core_req_data  in  NUM_CORES*LINE_W  per-core write data, same packing
core_req_ready  out  NUM_CORES  one-hot accept pulse
core_resp_valid  out  NUM_CORES  one-hot completion pulse
core_resp_data  out  LINE_W  read data, shared by all cores
mem_req_valid  out  1  request to memory
mem_req_rw  out  1  0=read 1=write
mem_req_addr  out  LINE_ADDR_W  line address
mem_req_data  out  LINE_W  write data
mem_req_ready  in  1  memory can accept
mem_resp_valid  in  1  one-cycle read response pulse
mem_resp_data  in  LINE_W  read data
err_timeout  out  1  watchdog pulse (optional feature)

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, rr_ptr=0, latched rw/addr/data/id=0; all outputs 0. Reset mid-transaction abandons it; a late mem_resp_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE: if any core_req_valid, winner = first set bit scanning from rr_ptr upward with wrap. core_req_ready[winner]=1 combinationally in that cycle only; at the posedge latch winner id, rw, addr, data; rr_ptr<=(winner+1) mod NUM_CORES; go to ISSUE. Requester holds fields stable until its ready. No valid -> stay IDLE, rr_ptr unchanged.
- ISSUE: mem_req_valid=1, mem_req_rw/addr/data from latches (stable). Handshake = mem_req_valid && mem_req_ready at posedge. Read -> WAIT_RESP. Write -> core_resp_valid[id] pulses for one cycle after handshake, core_resp_data=0, go IDLE. mem_req_valid drops the cycle after handshake; exactly one handshake per transaction.
- WAIT_RESP: mem_req_valid=0. On mem_resp_valid: core_resp_valid[id]=1 and core_resp_data=mem_resp_data, registered, for exactly the next cycle; go IDLE.
- mem_resp_valid outside WAIT_RESP is ignored.
- Latency: accept at cycle 0, mem_req_valid from cycle 1; if mem_req_ready=1, handshake at cycle 1. Read completion = memory latency + 1 cycle.
- core_resp pulse and a new IDLE accept may occur in the same cycle.
- core_req_ready and core_resp_valid are each at most one-hot; never two grants per cycle.
- mem_req_valid stays high in ISSUE while mem_req_ready=0 (e.g. memory still busy with a prior write).

Optional Feature:
MEM_ARB_TIMEOUT_EN: cycle counter cleared on WAIT_RESP entry; if TIMEOUT_CYCLES cycles pass without mem_resp_valid, err_timeout pulses one cycle, core_resp_valid[id] pulses with core_resp_data=0, state returns to IDLE. Without the macro: no counter, err_timeout tied 0, WAIT_RESP waits indefinitely.

Test Plan:
- Core 1 reads addr 0x12 (memory holds 0xA5..): core_req_ready[1] pulses cycle 0; mem_req_valid, rw=0, addr=0x12 at cycle 1; core_resp_valid=4'b0010 with data 0xA5.. one cycle after mem_resp_valid.
- Core 2 writes 0x34 data 0xDEADBEEF.. then core 0 reads 0x34: write handshake then core_resp_valid[2] pulse; core 0 read issued only once mem_req_ready returns high; it returns 0xDEADBEEF..
- All 4 cores hold valid continuously from reset: grant order 0,1,2,3,0 and no core is granted twice before the others.
- rr_ptr=2, only cores 0 and 3 valid: core 3 granted first, then core 0.
- reset_n low 3 cycles while in WAIT_RESP: all outputs 0; the later mem_resp_valid produces no core_resp_valid; the next request proceeds normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds: err_timeout and core_resp_valid[id] pulse 8 cycles after WAIT_RESP entry with data 0; the next request is accepted.
